sd_cmd_engine: RTL and testbench

Serial engine for the SD CMD line, directly downstream of the SD host controller's clock divider and register file. Accepts one command at a time (index, argument, response type) and shifts out the 48-bit frame with CRC7. It then releases the line and captures the card's 48- or 136-bit response, checking CRC7, end bit and response timeout. The controller core supplies sd_clk edge strobes and consumes `done`, the error flags and the response.

---
 rtl/sd_pkg.sv | 31 +++
 rtl/sd_cmd_engine_if.sv | 24 ++
 rtl/sd_crc7.sv | 28 ++
 rtl/sd_cmd_engine.sv | 173 +++++++++++++++++
 tb/tb_sd_cmd_engine.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/sd_pkg.sv
// Shared types and constants for the SD CMD line engine.
// Includes the serial CRC7 step used by every CRC7 instance.
package sd_pkg;

  typedef enum logic [1:0] {
    RSP_NONE = 2'd0,
    RSP_R48  = 2'd1,
    RSP_R3   = 2'd2,
    RSP_R136 = 2'd3
  } rsp_type_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_TX    = 3'd1,
    ST_WAIT  = 3'd2,
    ST_RX    = 3'd3,
    ST_DRAIN = 3'd4
  } state_e;

  localparam logic [6:0] CRC7_POLY    = 7'h09;
  localparam int         FRAME_LEN48  = 48;
  localparam int         FRAME_LEN136 = 136;

  // One MSB-first step of x^7+x^3+1.
  function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic din);
    logic fb;
    fb = din ^ crc[6];
    return {crc[5:0], 1'b0} ^ (fb ? CRC7_POLY : 7'h00);
  endfunction

endpackage

// File: rtl/sd_cmd_engine_if.sv
// Command request / response bundle between the host controller core
// (master) and the CMD line engine (slave).
interface sd_cmd_engine_if;
  logic         start;
  logic [5:0]   cmd_idx;
  logic [31:0]  cmd_arg;
  logic [1:0]   rsp_type;
  logic         busy;
  logic         done;
  logic         err_timeout;
  logic         err_crc;
  logic [5:0]   rsp_idx;
  logic [127:0] rsp;

  modport master (
    output start, cmd_idx, cmd_arg, rsp_type,
    input  busy, done, err_timeout, err_crc, rsp_idx, rsp
  );

  modport slave (
    input  start, cmd_idx, cmd_arg, rsp_type,
    output busy, done, err_timeout, err_crc, rsp_idx, rsp
  );
endinterface

// File: rtl/sd_crc7.sv
// Serial CRC7 accumulator; clr has priority over en.
module sd_crc7
  import sd_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       en,
  input  logic       din,
  output logic [6:0] crc
);

  logic [6:0] crc_r;

  // CRC shift register
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      crc_r <= 7'h00;
    end else if (en) begin
      crc_r <= crc7_step(crc_r, din);
    end else begin
      crc_r <= crc_r;
    end
  end

  assign crc = crc_r;

endmodule

// File: rtl/sd_cmd_engine.sv
// SD CMD line engine: shifts out a 48-bit command with CRC7, then captures
// and checks the card's R48/R136 response, with timeout and line drain.
module sd_cmd_engine
  import sd_pkg::*;
#(
  parameter int TIMEOUT = 64,
  parameter int DRAIN   = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                tx_tick,
  input  logic                rx_tick,
  sd_cmd_engine_if.slave      io,
  output logic                sd_cmd_o,
  output logic                sd_cmd_oe,
  input  logic                sd_cmd_i
);

  state_e       state_r, state_s;
  rsp_type_e    type_r, type_s;
  logic [15:0]  cnt_r, cnt_s;
  logic [39:0]  hdr_r, hdr_s;
  logic [126:0] rx_sh_r, rx_sh_s;
  logic         busy_r, busy_s, done_r, done_s;
  logic         err_to_r, err_to_s, err_crc_r, err_crc_s;
  logic [5:0]   rsp_idx_r, rsp_idx_s;
  logic [127:0] rsp_r, rsp_s;
  logic         cmd_o_r, cmd_o_s, cmd_oe_r, cmd_oe_s;
  logic         crc_clr_s, tx_en_s, rx_en_s, tx_bit_s;
  logic [6:0]   tx_crc, rx_crc;
  logic [5:0]   pos_s;
  logic [15:0]  len_s, skip_s;

  sd_crc7 u_tx_crc (.clk(clk), .rst(rst), .clr(crc_clr_s), .en(tx_en_s), .din(tx_bit_s), .crc(tx_crc));
  sd_crc7 u_rx_crc (.clk(clk), .rst(rst), .clr(crc_clr_s), .en(rx_en_s), .din(sd_cmd_i), .crc(rx_crc));

  assign pos_s  = cnt_r[5:0];
  // R136 excludes its 8 header bits from the CRC; R48's start bit is 0 and leaves a cleared CRC unchanged.
  assign len_s  = (type_r == RSP_R136) ? 16'(FRAME_LEN136) : 16'(FRAME_LEN48);
  assign skip_s = (type_r == RSP_R136) ? 16'd8 : 16'd1;

  // Outgoing bit for the current frame position
  always_comb begin
    if (cnt_r < 16'd40) begin
      tx_bit_s = hdr_r[6'd39 - pos_s];
    end else if (cnt_r < 16'd47) begin
      tx_bit_s = tx_crc[3'(6'd46 - pos_s)];
    end else begin
      tx_bit_s = 1'b1;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_s   = state_r;   cnt_s     = cnt_r;     hdr_s    = hdr_r;
    type_s    = type_r;    rx_sh_s   = rx_sh_r;   busy_s   = busy_r;
    done_s    = 1'b0;      err_to_s  = err_to_r;  err_crc_s = err_crc_r;
    rsp_s     = rsp_r;     rsp_idx_s = rsp_idx_r; cmd_o_s  = cmd_o_r;
    cmd_oe_s  = cmd_oe_r;  crc_clr_s = 1'b0;      tx_en_s  = 1'b0;
    rx_en_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (io.start) begin
          hdr_s     = {2'b01, io.cmd_idx, io.cmd_arg};
          type_s    = rsp_type_e'(io.rsp_type);
          cnt_s     = 16'd0;
          busy_s    = 1'b1;
          err_to_s  = 1'b0;
          err_crc_s = 1'b0;
          crc_clr_s = 1'b1;
          state_s   = ST_TX;
        end else begin
          busy_s = 1'b0;
        end
      end
      ST_TX: begin
        if (!tx_tick) begin
          state_s = ST_TX;
        end else if (cnt_r == 16'(FRAME_LEN48)) begin
          cmd_o_s  = 1'b1;
          cmd_oe_s = 1'b0;
          cnt_s    = 16'd0;
          state_s  = (type_r == RSP_NONE) ? ST_DRAIN : ST_WAIT;
        end else begin
          cmd_o_s  = tx_bit_s;
          cmd_oe_s = 1'b1;
          tx_en_s  = (cnt_r < 16'd40);
          cnt_s    = cnt_r + 16'd1;
        end
      end
      ST_WAIT: begin
        if (!rx_tick) begin
          state_s = ST_WAIT;
        end else if (!sd_cmd_i) begin
          cnt_s   = 16'd1;
          state_s = ST_RX;
        end else if (cnt_r == 16'(TIMEOUT - 1)) begin
          err_to_s = 1'b1;
          cnt_s    = 16'd0;
          state_s  = ST_DRAIN;
        end else begin
          cnt_s = cnt_r + 16'd1;
        end
      end
      ST_RX: begin
        if (!rx_tick) begin
          state_s = ST_RX;
        end else begin
          rx_sh_s = {rx_sh_r[125:0], sd_cmd_i};
          rx_en_s = (cnt_r >= skip_s) && (cnt_r < len_s - 16'd8);
          if (cnt_r == len_s - 16'd1) begin
            // rx_sh_r holds frame bit k at index k-1; sd_cmd_i is the end bit.
            err_crc_s = !sd_cmd_i || ((type_r != RSP_R3) && (rx_sh_r[6:0] != rx_crc));
            if (type_r == RSP_R136) begin
              rsp_s = {rx_sh_r, sd_cmd_i};
            end else begin
              rsp_s     = {96'd0, rx_sh_r[38:7]};
              rsp_idx_s = rx_sh_r[44:39];
            end
            cnt_s   = 16'd0;
            state_s = ST_DRAIN;
          end else begin
            cnt_s = cnt_r + 16'd1;
          end
        end
      end
      ST_DRAIN: begin
        if (!tx_tick) begin
          state_s = ST_DRAIN;
        end else if (cnt_r == 16'(DRAIN - 1)) begin
          done_s  = 1'b1;
          busy_s  = 1'b0;
          cnt_s   = 16'd0;
          state_s = ST_IDLE;
        end else begin
          cnt_s = cnt_r + 16'd1;
        end
      end
      default: begin
        state_s  = ST_IDLE;
        busy_s   = 1'b0;
        cmd_oe_s = 1'b0;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;   cnt_r     <= 16'd0;    hdr_r    <= 40'd0;
      type_r  <= RSP_NONE;  rx_sh_r   <= 127'd0;   busy_r   <= 1'b0;
      done_r  <= 1'b0;      err_to_r  <= 1'b0;     err_crc_r <= 1'b0;
      rsp_r   <= 128'd0;    rsp_idx_r <= 6'd0;     cmd_o_r  <= 1'b1;
      cmd_oe_r <= 1'b0;
    end else begin
      state_r <= state_s;   cnt_r     <= cnt_s;     hdr_r    <= hdr_s;
      type_r  <= type_s;    rx_sh_r   <= rx_sh_s;   busy_r   <= busy_s;
      done_r  <= done_s;    err_to_r  <= err_to_s;  err_crc_r <= err_crc_s;
      rsp_r   <= rsp_s;     rsp_idx_r <= rsp_idx_s; cmd_o_r  <= cmd_o_s;
      cmd_oe_r <= cmd_oe_s;
    end
  end

  assign io.busy        = busy_r;
  assign io.done        = done_r;
  assign io.err_timeout = err_to_r;
  assign io.err_crc     = err_crc_r;
  assign io.rsp_idx     = rsp_idx_r;
  assign io.rsp         = rsp_r;
  assign sd_cmd_o       = cmd_o_r;
  assign sd_cmd_oe      = cmd_oe_r;

endmodule

// File: tb/tb_sd_cmd_engine.sv
// Table-driven bench for sd_cmd_engine with a card model on the CMD line
// and a scoreboard of expected frames / responses.
module tb_sd_cmd_engine;

  logic clk = 1'b0, rst = 1'b1, tx_tick = 1'b0, rx_tick = 1'b0, sd_cmd_i = 1'b1;
  logic sd_cmd_o, sd_cmd_oe;

  sd_cmd_engine_if io();

  sd_cmd_engine #(.TIMEOUT(64), .DRAIN(8)) dut (
    .clk(clk), .rst(rst), .tx_tick(tx_tick), .rx_tick(rx_tick), .io(io),
    .sd_cmd_o(sd_cmd_o), .sd_cmd_oe(sd_cmd_oe), .sd_cmd_i(sd_cmd_i)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]   idx;  logic [31:0] arg;  logic [1:0] typ;
    int           dly;  logic [135:0] resp; int len;
    logic [47:0]  fr;   logic [5:0] ei; logic ci; logic [127:0] er; logic eto; logic ecrc;
  } vec_t;

  typedef struct {
    logic [47:0] fr; logic [5:0] ei; logic ci; logic [127:0] er; logic eto; logic ecrc;
  } exp_t;

  vec_t tbl[7];
  exp_t sb[$];
  int n_chk = 0, n_fail = 0, done_cnt = 0;

  // sd_clk strobes: falling-edge (tx) and rising-edge (rx) every 4 clk cycles
  initial begin
    int ph;
    ph = 0;
    forever begin
      @(negedge clk);
      ph = (ph + 1) % 4;
      tx_tick = (ph == 0);
      rx_tick = (ph == 2);
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (io.done === 1'b1) done_cnt++;
    end
  end

  function automatic logic [6:0] crc7_120(input logic [119:0] d);
    logic [6:0] c;
    logic fb;
    c = 7'd0;
    for (int i = 119; i >= 0; i--) begin
      fb = d[i] ^ c[6];
      c = {c[5:0], 1'b0};
      if (fb) c = c ^ 7'h09;
    end
    return c;
  endfunction

  function automatic vec_t mk(logic [5:0] idx, logic [31:0] arg, logic [1:0] typ, int dly,
                              logic [135:0] resp, int len, logic [47:0] fr, logic [5:0] ei,
                              logic ci, logic [127:0] er, logic eto, logic ecrc);
    vec_t v;
    v.idx = idx; v.arg = arg; v.typ = typ; v.dly = dly; v.resp = resp; v.len = len;
    v.fr = fr; v.ei = ei; v.ci = ci; v.er = er; v.eto = eto; v.ecrc = ecrc;
    return v;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wait_tick(input bit rx);
    int n;
    n = 0;
    do begin
      @(posedge clk);
      n++;
    end while (((rx ? rx_tick : tx_tick) !== 1'b1) && n < 16);
    if ((rx ? rx_tick : tx_tick) !== 1'b1) begin
      n_chk++;
      n_fail++;
      $display("FAIL tick_wait: no %s tick within 16 cycles", rx ? "rx" : "tx");
    end
  endtask

  task automatic run_row(input vec_t v, input bit poke);
    exp_t e;
    logic [47:0] frame;
    logic oe_all;
    int d0, ndrain, k;
    e.fr = v.fr; e.ei = v.ei; e.ci = v.ci; e.er = v.er; e.eto = v.eto; e.ecrc = v.ecrc;
    sb.push_back(e);
    d0 = done_cnt;
    frame = 48'd0;
    oe_all = 1'b1;
    @(negedge clk);
    io.cmd_idx = v.idx; io.cmd_arg = v.arg; io.rsp_type = v.typ; io.start = 1'b1;
    @(posedge clk);
    #1 io.start = 1'b0;
    chk("busy_rise", io.busy, 1'b1);
    chk("err_cleared", {io.err_timeout, io.err_crc}, 2'b00);
    for (int i = 0; i < 48; i++) begin
      wait_tick(1'b0);
      #1;
      frame = {frame[46:0], sd_cmd_o};
      oe_all = oe_all & sd_cmd_oe;
      if (poke && i == 10) begin
        io.start = 1'b1; io.cmd_idx = 6'h11;
        @(posedge clk);
        #1 io.start = 1'b0; io.cmd_idx = v.idx;
      end
    end
    chk("tx_oe", oe_all, 1'b1);
    wait_tick(1'b0);
    #1 chk("release_oe", sd_cmd_oe, 1'b0);
    if (v.typ != 2'd0) begin
      sd_cmd_i = 1'b1;
      if (v.dly < 0) begin
        for (int j = 0; j < 63; j++) begin
          wait_tick(1'b1);
          #1;
        end
        chk("timeout_early", io.err_timeout, 1'b0);
        wait_tick(1'b1);
        #1 chk("timeout_at_64", io.err_timeout, 1'b1);
      end else begin
        for (int j = 0; j < v.dly; j++) begin
          wait_tick(1'b1);
          #1;
        end
        for (int b = v.len - 1; b >= 0; b--) begin
          sd_cmd_i = v.resp[b];
          wait_tick(1'b1);
          #1;
        end
        sd_cmd_i = 1'b1;
      end
    end
    ndrain = 0;
    k = 0;
    while (io.done !== 1'b1 && k < 200) begin
      @(posedge clk);
      if (tx_tick) ndrain++;
      #1;
      k++;
    end
    chk("done_seen", io.done, 1'b1);
    chk("drain_ticks", ndrain, 8);
    chk("busy_at_done", io.busy, 1'b0);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("tx_frame", frame, e.fr);
      if (e.ci) chk("rsp_idx", io.rsp_idx, e.ei);
      chk("rsp", io.rsp, e.er);
      chk("err_timeout", io.err_timeout, e.eto);
      chk("err_crc", io.err_crc, e.ecrc);
    end else begin
      chk("scoreboard_empty", sb.size(), 1);
    end
    repeat (20) @(posedge clk);
    #1 chk("one_done", done_cnt - d0, 1);
  endtask

  initial begin
    logic [119:0] cid;
    logic [135:0] r136_ok, r136_bad;
    int d0;
    io.start = 1'b0; io.cmd_idx = 6'd0; io.cmd_arg = 32'd0; io.rsp_type = 2'd0;

    cid      = 120'h0353_4453_4431_3647_8012_3456_789A_BC;
    r136_ok  = {8'h3F, cid, crc7_120(cid), 1'b1};
    r136_bad = {8'h3F, cid, crc7_120(cid), 1'b0};
    tbl[0] = mk(6'd0, 32'h0,   2'd0, 0,  136'd0, 0, 48'h40_0000_0000_95, 6'd0, 1'b1, 128'd0, 1'b0, 1'b0);
    tbl[1] = mk(6'd8, 32'h1AA, 2'd1, 2,  {88'd0, 48'h08_0000_01AA_13}, 48, 48'h48_0000_01AA_87,
                6'd8, 1'b1, 128'h1AA, 1'b0, 1'b0);
    tbl[2] = mk(6'd8, 32'h1AA, 2'd1, 0,  {88'd0, 48'h08_0000_01AA_11}, 48, 48'h48_0000_01AA_87,
                6'd8, 1'b1, 128'h1AA, 1'b0, 1'b1);
    tbl[3] = mk(6'd8, 32'h1AA, 2'd2, 5,  {88'd0, 48'h08_0000_01AA_11}, 48, 48'h48_0000_01AA_87,
                6'd8, 1'b1, 128'h1AA, 1'b0, 1'b0);
    tbl[4] = mk(6'd8, 32'h1AA, 2'd1, -1, 136'd0, 0, 48'h48_0000_01AA_87,
                6'd8, 1'b1, 128'h1AA, 1'b1, 1'b0);
    tbl[5] = mk(6'd2, 32'h0,   2'd3, 3,  r136_ok, 136, 48'h42_0000_0000_4D,
                6'd0, 1'b0, r136_ok[127:0], 1'b0, 1'b0);
    tbl[6] = mk(6'd2, 32'h0,   2'd3, 1,  r136_bad, 136, 48'h42_0000_0000_4D,
                6'd0, 1'b0, r136_bad[127:0], 1'b0, 1'b1);

    repeat (3) @(posedge clk);
    #1;
    chk("rst_cmd_o", sd_cmd_o, 1'b1);
    chk("rst_oe", sd_cmd_oe, 1'b0);
    chk("rst_busy", io.busy, 1'b0);
    chk("rst_done", io.done, 1'b0);
    chk("rst_errs", {io.err_timeout, io.err_crc}, 2'b00);
    chk("rst_rsp", io.rsp, 128'd0);
    chk("rst_rsp_idx", io.rsp_idx, 6'd0);
    rst = 1'b0;

    for (int i = 0; i < 7; i++) run_row(tbl[i], i == 1);

    d0 = done_cnt;
    @(negedge clk);
    io.cmd_idx = 6'd0; io.cmd_arg = 32'd0; io.rsp_type = 2'd0; io.start = 1'b1;
    @(posedge clk);
    #1 io.start = 1'b0;
    for (int i = 0; i < 20; i++) wait_tick(1'b0);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_oe", sd_cmd_oe, 1'b0);
    chk("midrst_busy", io.busy, 1'b0);
    chk("midrst_cmd_o", sd_cmd_o, 1'b1);
    chk("midrst_errs", {io.err_timeout, io.err_crc}, 2'b00);
    chk("midrst_rsp", io.rsp, 128'd0);
    rst = 1'b0;
    repeat (400) @(posedge clk);
    #1 chk("midrst_no_done", done_cnt - d0, 0);
    run_row(tbl[0], 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
